// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one result bit per cycle
// on operand magnitudes, fixes up signs and special cases in one extra cycle,
// then drives the register-bank write port for a single cycle.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   start      request; accepted when start=1 and busy=0
//   funct3     op select (000 MUL .. 111 REMU)
//   rd         destination register index
//   operand_a  rs1 value
//   operand_b  rs2 value
//   busy       high from the edge after accept until writeback completes
//   done       one-cycle pulse in the writeback cycle
//   wb_we      register-bank write enable (suppressed for rd = 0)
//   wb_sel     register-bank write index
//   wb_data    register-bank write data
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_sel,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t              state, state_next;
    op_t                 op_q;
    logic [4:0]          rd_q;
    logic                sign_a, sign_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   acc;

    logic                accept;
    logic                a_signed_in, b_signed_in;
    logic                neg_a_in, neg_b_in;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   acc_step;

    logic                mul_neg;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, remv, quot_s, rem_s, orig_a;
    logic                b_zero;
    logic [XLEN-1:0]     fix_result;

    assign accept = start && !busy && (state == IDLE);

    // Operand signedness by op: a is signed for MULH/MULHSU/DIV/REM,
    // b only for MULH/DIV/REM.
    always_comb begin
        a_signed_in = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV)  || (funct3 == OP_REM);
        b_signed_in = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                      (funct3 == OP_REM);
        neg_a_in    = a_signed_in && operand_a[XLEN-1];
        neg_b_in    = b_signed_in && operand_b[XLEN-1];
    end

    // One iteration of either algorithm on the shared accumulator.
    // Multiply: acc = {partial_hi, multiplier}, shift-add then shift right.
    // Divide:   acc = {remainder, dividend/quotient}, restoring shift-subtract.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, mag_b};
        if (op_q[2]) begin
            if (div_diff[XLEN+1])
                acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection. The signed-overflow case
    // (0x80000000 / -1) falls out of the magnitude path directly:
    // |q| = 2^31 with positive sign encodes as 0x80000000 and rem = 0.
    always_comb begin
        mul_neg    = (op_q == OP_MULHSU) ? sign_a : (sign_a ^ sign_b);
        prod       = mul_neg ? (~acc + 1'b1) : acc;
        quot       = acc[XLEN-1:0];
        remv       = acc[2*XLEN-1:XLEN];
        quot_s     = (sign_a ^ sign_b) ? (~quot + 1'b1) : quot;
        rem_s      = sign_a ? (~remv + 1'b1) : remv;
        orig_a     = sign_a ? (~mag_a + 1'b1) : mag_a;
        b_zero     = (mag_b == '0);
        fix_result = '0;
        unique case (op_q)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = b_zero ? '1 : quot_s;
            OP_REM, OP_REMU:              fix_result = b_zero ? orig_a : rem_s;
            default:                      fix_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (count == CW'(XLEN-1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= OP_MUL;
            rd_q    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
            count   <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_sel  <= '0;
            wb_data <= '0;
        end else begin
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_sel  <= '0;
            wb_data <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_t'(funct3);
                        rd_q   <= rd;
                        sign_a <= neg_a_in;
                        sign_b <= neg_b_in;
                        mag_a  <= neg_a_in ? (~operand_a + 1'b1) : operand_a;
                        mag_b  <= neg_b_in ? (~operand_b + 1'b1) : operand_b;
                        acc    <= {{XLEN{1'b0}},
                                   neg_a_in ? (~operand_a + 1'b1) : operand_a};
                        count  <= '0;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    done    <= 1'b1;
                    wb_we   <= (rd_q != 5'd0);
                    wb_sel  <= rd_q;
                    wb_data <= fix_result;
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors with hand-computed results.
// Stimulus pushes expected writebacks into a queue; a monitor on the falling
// edge pops and compares whenever done is presented.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;

    muldiv_unit #(.XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .rd        (rd),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs [32] = '{default: '0};

    // Cycle counter and a register bank model fed by the write port.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (wb_we && wb_sel != 5'd0) regs[wb_sel] <= wb_data;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Monitor: compare each writeback against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb actual sel=%0d we=%0b data=%h required none",
                             wb_sel, wb_we, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_sel", {27'b0, wb_sel}, {27'b0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_we", {31'b0, wb_we}, {31'b0, (e.rd != 5'd0)});
                    chk("latency", cyc, e.due);
                end
            end else if (wb_we || wb_sel != 5'd0 || wb_data != 32'd0) begin
                errors++;
                $display("FAIL idle_outputs actual we=%0b sel=%0d data=%h required 0",
                         wb_we, wb_sel, wb_data);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input bit push);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("wait_not_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        start     = 1'b1;
        funct3    = f;
        rd        = r;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        // Upstream is free to change operands after the accept edge.
        operand_a = $urandom;
        operand_b = $urandom;
        funct3    = 3'($urandom);
        rd        = 5'($urandom);
        if (push) exp_q.push_back('{rd: r, data: expv, due: cyc + 33});
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("completion_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
    endtask

    vec_t vecs [15] = '{
        '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000},  // MULH
        '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},  // MULHU
        '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},  // MULHSU
        '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE},  // MUL
        '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},  // DIV -7/2
        '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},  // REM -7%2
        '{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC},  // DIVU
        '{3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001},  // REMU
        '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF},  // DIVU /0
        '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005},  // REMU %0
        '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},  // DIV overflow
        '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},  // REM overflow
        '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF},  // DIV -7/0
        '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},  // REM -7%0
        '{3'b100, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2}   // DIV 100/-7
    };

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_busy",    {31'b0, busy},  32'd0);
        chk("reset_done",    {31'b0, done},  32'd0);
        chk("reset_wb_we",   {31'b0, wb_we}, 32'd0);
        chk("reset_wb_sel",  {27'b0, wb_sel}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        reset = 1'b0;

        // MUL 7 x 6 -> x5
        issue(3'b000, 5'd5, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_idle();
        chk("x5", regs[5], 32'd42);

        foreach (vecs[i]) begin
            issue(vecs[i].f, 5'(10 + i), vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
        end
        wait_idle();

        // start while busy is ignored
        issue(3'b000, 5'd7, 32'd100, 32'd3, 32'd300, 1'b1);
        repeat (10) @(negedge clock);
        start     = 1'b1;
        funct3    = 3'b000;
        rd        = 5'd8;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        chk("x7", regs[7], 32'd300);
        chk("x8_untouched", regs[8], 32'd0);

        // rd = 0: done pulses, no write enable
        issue(3'b000, 5'd0, 32'd3, 32'd4, 32'd12, 1'b1);
        wait_idle();

        // reset 10 edges after accept discards the op
        issue(3'b000, 5'd9, 32'd11, 32'd13, 32'd143, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("busy_after_reset", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("x9_untouched", regs[9], 32'd0);

        // MULHU 3 x 5 -> 0 in x1
        issue(3'b011, 5'd1, 32'd3, 32'd5, 32'd0, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
